// File: rtl/msg_rr_arb_pkg.sv
// Shared constants for the message round-robin arbiter: field widths,
// handshake levels and the arbiter state encoding.
package msg_rr_arb_pkg;

   localparam logic NS_ON  = 1'b1;
   localparam logic NS_OFF = 1'b0;

   localparam int NS_ADDRESS_SIZE = 8;
   localparam int NS_DATA_SIZE    = 16;
   localparam int NS_REDUN_SIZE   = 4;

   function automatic int msg_width(input int asz, input int dsz, input int rsz);
      return 2 * asz + dsz + rsz;
   endfunction

   localparam int MSZ = msg_width(NS_ADDRESS_SIZE, NS_DATA_SIZE, NS_REDUN_SIZE);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_XFER = 2'd2
   } arb_st_t;

endpackage

// File: rtl/msg_rr_arb_rr_pick.sv
// Round-robin picker: first set bit of i_mask strictly after i_last,
// wrapping from NSRC-1 back to 0.
module rr_pick #(
   parameter int NSRC = 4,
   parameter int IDXW = $clog2(NSRC)
) (
   input  logic [NSRC-1:0] i_mask,
   input  logic [IDXW-1:0] i_last,
   output logic            o_valid,
   output logic [IDXW-1:0] o_idx
);

   logic [2*NSRC-1:0] w_dbl;
   logic [NSRC-1:0]   w_rot;
   logic [IDXW:0]     w_start;
   logic [IDXW:0]     w_enc;
   logic [IDXW:0]     w_sum;

   // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
   always_comb begin
      w_start = {1'b0, i_last} + (IDXW+1)'(1);
      w_dbl   = {i_mask, i_mask} >> w_start;
      w_rot   = w_dbl[NSRC-1:0];
      o_valid = |w_rot;
      w_enc   = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (w_rot[i]) w_enc = (IDXW+1)'(i);
      end
      // Undo the rotation; the sum is below 2*NSRC so one subtraction suffices.
      w_sum = w_start + w_enc;
      if (w_sum >= (IDXW+1)'(NSRC)) w_sum = w_sum - (IDXW+1)'(NSRC);
      o_idx = w_sum[IDXW-1:0];
   end

endmodule

// File: rtl/msg_rr_arb.sv
// NSRC:1 round-robin merge of four-phase message channels onto one snd
// channel; one message in flight, both handshakes finish before the next grant.
module msg_rr_arb
   import msg_rr_arb_pkg::*;
#(
   parameter int NSRC = 4,
   parameter int ASZ  = NS_ADDRESS_SIZE,
   parameter int DSZ  = NS_DATA_SIZE,
   parameter int RSZ  = NS_REDUN_SIZE,
   parameter int IDXW = $clog2(NSRC)
) (
   input  logic                i_clk,
   input  logic                reset,
   output logic                ready,
   input  logic [NSRC-1:0]     rcv_req,
   output logic [NSRC-1:0]     rcv_ack,
   input  logic [NSRC*ASZ-1:0] rcv_src,
   input  logic [NSRC*ASZ-1:0] rcv_dst,
   input  logic [NSRC*DSZ-1:0] rcv_dat,
   input  logic [NSRC*RSZ-1:0] rcv_red,
   output logic                snd_req,
   input  logic                snd_ack,
   output logic [ASZ-1:0]      snd_src,
   output logic [ASZ-1:0]      snd_dst,
   output logic [DSZ-1:0]      snd_dat,
   output logic [RSZ-1:0]      snd_red,
   output logic [IDXW-1:0]     grant
);

   localparam int MW = msg_width(ASZ, DSZ, RSZ);

   arb_st_t         r_state;
   logic            r_ready;
   logic            r_snd_req;
   logic [NSRC-1:0] r_rcv_ack;
   logic [IDXW-1:0] r_grant;
   logic [IDXW-1:0] r_last;
   logic [MW-1:0]   r_msg;
   logic            r_in_done;
   logic            r_out_done;

   logic [NSRC-1:0] w_mask;
   logic            w_pick_valid;
   logic [IDXW-1:0] w_pick_idx;
   logic [MW-1:0]   w_pick_msg;
   logic            w_in_done;
   logic            w_out_done;

   assign w_mask     = rcv_req & ~r_rcv_ack;
   assign w_pick_msg = {rcv_src[w_pick_idx*ASZ +: ASZ], rcv_dst[w_pick_idx*ASZ +: ASZ],
                        rcv_dat[w_pick_idx*DSZ +: DSZ], rcv_red[w_pick_idx*RSZ +: RSZ]};

   // Output side is done once snd_req has already dropped and the ack follows it down.
   assign w_in_done  = r_in_done | ~rcv_req[r_grant];
   assign w_out_done = r_out_done | (~r_snd_req & ~snd_ack);

   rr_pick #(
      .NSRC (NSRC),
      .IDXW (IDXW)
   ) u_pick (
      .i_mask  (w_mask),
      .i_last  (r_last),
      .o_valid (w_pick_valid),
      .o_idx   (w_pick_idx)
   );

   // NOTE: state updates use <= so every branch reads the pre-edge values.
   always_ff @(posedge i_clk) begin
      if (reset) begin
         r_state    <= ST_INIT;
         r_ready    <= NS_OFF;
         r_snd_req  <= NS_OFF;
         r_rcv_ack  <= '0;
         r_grant    <= '0;
         r_last     <= IDXW'(NSRC - 1);
         r_msg      <= '0;
         r_in_done  <= NS_OFF;
         r_out_done <= NS_OFF;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_ready <= NS_ON;
               r_state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (!snd_ack && w_pick_valid) begin
                  r_msg      <= w_pick_msg;
                  r_grant    <= w_pick_idx;
                  r_last     <= w_pick_idx;
                  r_snd_req  <= NS_ON;
                  r_rcv_ack  <= NSRC'(1) << w_pick_idx;
                  r_in_done  <= NS_OFF;
                  r_out_done <= NS_OFF;
                  r_state    <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (!rcv_req[r_grant]) r_rcv_ack[r_grant] <= NS_OFF;
               if (r_snd_req && snd_ack) r_snd_req <= NS_OFF;
               r_in_done  <= w_in_done;
               r_out_done <= w_out_done;
               if (w_in_done && w_out_done) r_state <= ST_IDLE;
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   assign ready   = r_ready;
   assign snd_req = r_snd_req;
   assign rcv_ack = r_rcv_ack;
   assign grant   = r_grant;
   assign {snd_src, snd_dst, snd_dat, snd_red} = r_msg;

endmodule

// File: tb/tb_msg_rr_arb.sv
// Self-checking bench for msg_rr_arb: directed handshake scenarios plus
// randomized multi-source traffic against a transaction-level reference model.
module tb_msg_rr_arb;
   import msg_rr_arb_pkg::*;

   localparam int NSRC = 4;
   localparam int ASZ  = NS_ADDRESS_SIZE;
   localparam int DSZ  = NS_DATA_SIZE;
   localparam int RSZ  = NS_REDUN_SIZE;
   localparam int IDXW = $clog2(NSRC);

   logic                i_clk = 1'b0;
   logic                reset = 1'b1;
   logic                ready;
   logic [NSRC-1:0]     rcv_req = '0;
   logic [NSRC-1:0]     rcv_ack;
   logic [NSRC*ASZ-1:0] rcv_src = '0;
   logic [NSRC*ASZ-1:0] rcv_dst = '0;
   logic [NSRC*DSZ-1:0] rcv_dat = '0;
   logic [NSRC*RSZ-1:0] rcv_red = '0;
   logic                snd_req;
   logic                snd_ack = 1'b0;
   logic [ASZ-1:0]      snd_src;
   logic [ASZ-1:0]      snd_dst;
   logic [DSZ-1:0]      snd_dat;
   logic [RSZ-1:0]      snd_red;
   logic [IDXW-1:0]     grant;

   msg_rr_arb #(.NSRC(NSRC), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .IDXW(IDXW)) dut (
      .i_clk   (i_clk),   .reset   (reset),   .ready   (ready),
      .rcv_req (rcv_req), .rcv_ack (rcv_ack), .rcv_src (rcv_src),
      .rcv_dst (rcv_dst), .rcv_dat (rcv_dat), .rcv_red (rcv_red),
      .snd_req (snd_req), .snd_ack (snd_ack), .snd_src (snd_src),
      .snd_dst (snd_dst), .snd_dat (snd_dat), .snd_red (snd_red),
      .grant   (grant)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: one message in flight; the input side and output side
   // each finish on their own, the next grant waits for both.
   localparam int M_INIT = 0, M_IDLE = 1, M_BUSY = 2;
   bit              m_valid = 0;
   int              m_phase;
   bit              m_ready, m_req_out, m_in_fin, m_out_fin;
   logic [NSRC-1:0] m_ack;
   int              m_grant, m_last;
   logic [ASZ-1:0]  m_src, m_dst;
   logic [DSZ-1:0]  m_dat;
   logic [RSZ-1:0]  m_red;

   always @(posedge i_clk) begin
      if (reset) begin
         m_valid = 1; m_phase = M_INIT; m_ready = 0; m_req_out = 0; m_ack = '0;
         m_grant = 0; m_last = NSRC - 1; m_src = '0; m_dst = '0; m_dat = '0; m_red = '0;
      end else if (m_phase == M_INIT) begin
         m_ready = 1; m_phase = M_IDLE;
      end else if (m_phase == M_IDLE) begin
         if (!snd_ack) begin
            for (int k = 1; k <= NSRC; k++) begin
               int c;
               c = (m_last + k) % NSRC;
               if (m_phase == M_IDLE && rcv_req[c]) begin
                  m_grant = c; m_last = c; m_phase = M_BUSY;
                  m_src = rcv_src[c*ASZ +: ASZ]; m_dst = rcv_dst[c*ASZ +: ASZ];
                  m_dat = rcv_dat[c*DSZ +: DSZ]; m_red = rcv_red[c*RSZ +: RSZ];
                  m_req_out = 1; m_ack = '0; m_ack[c] = 1'b1;
                  m_in_fin = 0; m_out_fin = 0;
               end
            end
         end
      end else begin
         if (!rcv_req[m_grant]) begin m_ack = '0; m_in_fin = 1; end
         if (m_req_out && snd_ack) m_req_out = 0;
         else if (!m_req_out && !snd_ack) m_out_fin = 1;
         if (m_in_fin && m_out_fin) m_phase = M_IDLE;
      end
   end

   int grant_log[$];
   bit prev_snd_req = 0;

   always @(negedge i_clk) begin
      if (m_valid) begin
         check("ready", ready, m_ready);
         check("snd_req", snd_req, m_req_out);
         check("rcv_ack", rcv_ack, m_ack);
         check("grant", grant, m_grant);
         check("snd_src", snd_src, m_src);
         check("snd_dst", snd_dst, m_dst);
         check("snd_dat", snd_dat, m_dat);
         check("snd_red", snd_red, m_red);
         if (snd_req && !prev_snd_req) grant_log.push_back(int'(grant));
         prev_snd_req = snd_req;
      end
   end

   // Stimulus agents: four-phase sources and a downstream sink with delays.
   int dn_cnt = 0;
   int dn_dly = 0;

   task automatic tick();
      @(negedge i_clk);
   endtask

   task automatic agents(input int p_raise, input int p_abort, input int dly_lo, input int dly_hi);
      for (int i = 0; i < NSRC; i++) begin
         if (rcv_req[i]) begin
            if (rcv_ack[i]) begin
               if ($urandom_range(99, 0) < 70) rcv_req[i] = 1'b0;
            end else if ($urandom_range(99, 0) < p_abort) begin
               rcv_req[i] = 1'b0;
            end
         end else if (!rcv_ack[i] && $urandom_range(99, 0) < p_raise) begin
            rcv_src[i*ASZ +: ASZ] = ASZ'($urandom);
            rcv_dst[i*ASZ +: ASZ] = ASZ'($urandom);
            rcv_dat[i*DSZ +: DSZ] = DSZ'($urandom);
            rcv_red[i*RSZ +: RSZ] = RSZ'($urandom);
            rcv_req[i] = 1'b1;
         end
      end
      if (snd_req != snd_ack) begin
         if (dn_cnt >= dn_dly) begin
            snd_ack = snd_req;
            dn_cnt  = 0;
            dn_dly  = $urandom_range(dly_hi, dly_lo);
         end else dn_cnt++;
      end else dn_cnt = 0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((rcv_req != '0 || rcv_ack != '0 || snd_req || snd_ack) && n < 200) begin
         agents(0, 0, 0, 2);
         tick();
         n++;
      end
      check("drain_idle", {rcv_req, rcv_ack, snd_req, snd_ack}, '0);
      tick();
   endtask

   task automatic one_msg(input int s, input logic [NSRC-1:0] exp_ack, input logic [ASZ-1:0] a,
                          input logic [ASZ-1:0] d, input logic [DSZ-1:0] dt, input logic [RSZ-1:0] r);
      rcv_src[s*ASZ +: ASZ] = a;
      rcv_dst[s*ASZ +: ASZ] = d;
      rcv_dat[s*DSZ +: DSZ] = dt;
      rcv_red[s*RSZ +: RSZ] = r;
      rcv_req[s] = 1'b1;
      tick();
      check("dir_snd_req_up", snd_req, 1);
      check("dir_rcv_ack_up", rcv_ack, exp_ack);
      check("dir_grant", grant, s);
      check("dir_fields", {snd_src, snd_dst, snd_dat, snd_red}, {a, d, dt, r});
      rcv_req[s] = 1'b0;
      snd_ack    = 1'b1;
      tick();
      check("dir_rcv_ack_down", rcv_ack, 0);
      check("dir_snd_req_down", snd_req, 0);
      snd_ack = 1'b0;
      tick();
   endtask

   initial begin
      int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
      int n;

      // Reset held three cycles, then one INIT cycle.
      repeat (3) tick();
      check("rst_ready", ready, 0);
      check("rst_snd_req", snd_req, 0);
      reset = 1'b0;
      tick();
      check("init_ready", ready, 1);
      check("init_rcv_ack", rcv_ack, 0);
      check("init_grant", grant, 0);

      // All sources requesting continuously, sink acks after two cycles.
      grant_log.delete();
      dn_cnt = 0;
      dn_dly = 2;
      n = 0;
      while (grant_log.size() < 6 && n < 300) begin
         agents(100, 0, 2, 2);
         tick();
         n++;
      end
      check("rr_seq_len", grant_log.size() >= 6, 1);
      for (int i = 0; i < 6; i++) begin
         if (i < grant_log.size()) check($sformatf("rr_seq[%0d]", i), grant_log[i], exp_seq[i]);
      end
      for (int i = 1; i < grant_log.size(); i++) begin
         check($sformatf("rr_no_repeat[%0d]", i), grant_log[i] != grant_log[i-1], 1);
      end
      drain();

      // Single messages; source 1 drops req as snd_ack rises, source 0 then
      // proves the arbiter is back in IDLE one cycle after snd_ack falls.
      one_msg(2, 4'b0100, 8'd5, 8'd9, 16'h000A, 4'h3);
      one_msg(1, 4'b0010, 8'h21, 8'h42, 16'hBEEF, 4'h7);
      one_msg(0, 4'b0001, 8'hFF, 8'h00, 16'hFFFF, 4'hF);

      // Stale downstream ack blocks arbitration.
      snd_ack    = 1'b1;
      rcv_req[0] = 1'b1;
      repeat (3) begin
         tick();
         check("stale_ack_hold", snd_req, 0);
      end
      snd_ack = 1'b0;
      tick();
      check("stale_ack_grant", snd_req, 1);
      check("stale_ack_rcv_ack", rcv_ack, 4'b0001);
      rcv_req[0] = 1'b0;
      snd_ack    = 1'b1;
      tick();
      snd_ack = 1'b0;
      tick();

      // Reset in the middle of a transfer from source 3.
      rcv_req = 4'b1000;
      tick();
      check("xfer_rcv_ack3", rcv_ack, 4'b1000);
      reset = 1'b1;
      tick();
      check("abort_snd_req", snd_req, 0);
      check("abort_rcv_ack", rcv_ack, 0);
      check("abort_ready", ready, 0);
      rcv_req = 4'b1010;
      tick();
      reset = 1'b0;
      tick();
      tick();
      check("post_rst_grant", grant, 1);
      check("post_rst_rcv_ack", rcv_ack, 4'b0010);
      dn_cnt = 0;
      dn_dly = 1;
      drain();

      // Randomized traffic with aborts, random sink delays and one reset pulse.
      for (int c = 0; c < 2500; c++) begin
         if (c == 1200) reset = 1'b1;
         if (c == 1203) reset = 1'b0;
         agents(30, 4, 0, 3);
         tick();
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
